uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_pkg.sv | 24 ++
 rtl/uart_tx_fifo_tx_fifo.sv | 67 ++++++
 rtl/uart_tx_fifo.sv | 153 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg
// Shared definitions for the buffered UART transmitter:
//   tx_state_t      - transmitter FSM state encoding
//   PAR_*           - parity_mode encodings (2'b11 behaves as PAR_NONE)
//   parity_enabled  - true when a parity bit is inserted into the frame
package uart_tx_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP1  = 3'd3,
    ST_STOP2  = 3'd4
  } tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_tx_fifo.sv
// tx_fifo
// Synchronous first-word-fall-through FIFO feeding the UART transmitter.
// Ports:
//   clk_50m, rst_n     - clock, asynchronous active-low reset
//   push, push_data    - write request and data
//   pop                - read request; pop_data is the head word
//   full, empty, level - occupancy status (level is 0..DEPTH)
// Handshake: a push is accepted on a rising edge when push=1 and full=0;
// a pop is accepted when pop=1 and empty=0. pop_data is valid whenever
// empty=0 and advances after an accepted pop. Rejected requests have no
// effect. An accepted push and pop in the same cycle leave level unchanged.
module tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk_50m,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     count;
  logic              push_ok;
  logic              pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage has no reset; only words covered by count are ever read.
  always_ff @(posedge clk_50m) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == LW'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Buffered UART transmitter: words written into a FIFO are sent as
// start / DATA_W data bits (LSB first) / optional parity / 1 or 2 stop bits.
// Every bit boundary is marked by a one-cycle clken tick.
// Ports:
//   clk_50m, rst_n          - clock, asynchronous active-low reset
//   din, wr_en              - FIFO write data and strobe
//   clken                   - bit-rate tick
//   parity_mode, stop2      - frame format, sampled when a word is popped
//   ovf_clr                 - clears the sticky overflow flag
//   tx, tx_busy             - serial line (idle high), frame in flight
//   full, empty, level      - FIFO status
//   overflow                - sticky: a write was attempted while full
//   state_dbg               - current transmitter FSM state
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                   clk_50m,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      din,
  input  logic                   wr_en,
  input  logic                   clken,
  input  logic [1:0]             parity_mode,
  input  logic                   stop2,
  input  logic                   ovf_clr,
  output logic                   tx,
  output logic                   tx_busy,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output tx_state_t              state_dbg
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  tx_state_t         state_q, state_n;
  logic              tx_q, tx_n;
  logic [DATA_W-1:0] shift_q, shift_n;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic              par_q, par_n;
  logic [1:0]        mode_q, mode_n;
  logic              s2_q, s2_n;
  logic              pop;
  logic [DATA_W-1:0] fifo_data;
  logic              ovf_q;

  tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_50m   (clk_50m),
    .rst_n     (rst_n),
    .push      (wr_en),
    .push_data (din),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // A write attempted while full sets the flag even if a pop frees a slot in
  // the same cycle; setting wins over a simultaneous clear.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n)              ovf_q <= 1'b0;
    else if (wr_en && full)  ovf_q <= 1'b1;
    else if (ovf_clr)        ovf_q <= 1'b0;
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tx_q    <= 1'b1;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      mode_q  <= PAR_NONE;
      s2_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      tx_q    <= tx_n;
      shift_q <= shift_n;
      cnt_q   <= cnt_n;
      par_q   <= par_n;
      mode_q  <= mode_n;
      s2_q    <= s2_n;
    end
  end

  // tx is registered: the value driven on a clken cycle is held for the whole
  // following bit interval. Going IDLE on the last stop clken lets the next
  // clken start a new frame with no gap.
  always_comb begin
    state_n = state_q;
    tx_n    = tx_q;
    shift_n = shift_q;
    cnt_n   = cnt_q;
    par_n   = par_q;
    mode_n  = mode_q;
    s2_n    = s2_q;
    pop     = 1'b0;
    if (clken) begin
      case (state_q)
        ST_IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            mode_n  = parity_mode;
            s2_n    = stop2;
            shift_n = fifo_data;
            cnt_n   = '0;
            par_n   = 1'b0;
            tx_n    = 1'b0;
            state_n = ST_DATA;
          end
        end
        ST_DATA: begin
          tx_n    = shift_q[0];
          shift_n = shift_q >> 1;
          par_n   = par_q ^ shift_q[0];
          cnt_n   = cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_W - 1))
            state_n = parity_enabled(mode_q) ? ST_PARITY : ST_STOP1;
        end
        ST_PARITY: begin
          tx_n    = (mode_q == PAR_ODD) ? ~par_q : par_q;
          state_n = ST_STOP1;
        end
        ST_STOP1: begin
          tx_n    = 1'b1;
          state_n = s2_q ? ST_STOP2 : ST_IDLE;
        end
        ST_STOP2: begin
          tx_n    = 1'b1;
          state_n = ST_IDLE;
        end
        default: begin
          tx_n    = 1'b1;
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  assign tx        = tx_q;
  assign tx_busy   = (state_q != ST_IDLE);
  assign overflow  = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
  import uart_tx_fifo_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk_50m = 1'b0;
  always #10 clk_50m = ~clk_50m;

  logic       rst_n       = 1'b0;
  logic       clken       = 1'b0;
  logic [1:0] parity_mode = PAR_NONE;
  logic       stop2       = 1'b0;
  logic       ovf_clr     = 1'b0;

  // 8-bit instance, DEPTH=4
  logic [7:0] din8   = '0;
  logic       wr_en8 = 1'b0;
  logic       tx8, busy8, full8, empty8, ovf8;
  logic [2:0] level8;
  tx_state_t  state8;

  // 5-bit instance, DEPTH=4
  logic [4:0] din5   = '0;
  logic       wr_en5 = 1'b0;
  logic       tx5, busy5, full5, empty5, ovf5;
  logic [2:0] level5;
  tx_state_t  state5;

  uart_tx_fifo #(.DATA_W(8), .DEPTH(4)) dut8 (
    .clk_50m(clk_50m), .rst_n(rst_n), .din(din8), .wr_en(wr_en8),
    .clken(clken), .parity_mode(parity_mode), .stop2(stop2),
    .ovf_clr(ovf_clr), .tx(tx8), .tx_busy(busy8), .full(full8),
    .empty(empty8), .level(level8), .overflow(ovf8), .state_dbg(state8)
  );

  uart_tx_fifo #(.DATA_W(5), .DEPTH(4)) dut5 (
    .clk_50m(clk_50m), .rst_n(rst_n), .din(din5), .wr_en(wr_en5),
    .clken(clken), .parity_mode(parity_mode), .stop2(stop2),
    .ovf_clr(ovf_clr), .tx(tx5), .tx_busy(busy5), .full(full5),
    .empty(empty5), .level(level5), .overflow(ovf5), .state_dbg(state5)
  );

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  int checks = 0;
  int fails  = 0;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Expected line bits for one frame, one entry per clken interval.
  task automatic model_frame(input logic [8:0] d, input int w,
                             input logic [1:0] m, input logic s2);
    logic par;
    par = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < w; i++) begin
      exp_q.push_back(d[i]);
      par = par ^ d[i];
    end
    if (m == 2'b01) exp_q.push_back(par);
    if (m == 2'b10) exp_q.push_back(~par);
    exp_q.push_back(1'b1);
    if (s2) exp_q.push_back(1'b1);
  endtask

  // ---------------- drivers ----------------
  // One clken pulse; on return tx reflects the value launched by that tick.
  task automatic tick();
    @(negedge clk_50m) clken = 1'b1;
    @(negedge clk_50m) clken = 1'b0;
  endtask

  task automatic push8(input logic [7:0] d);
    @(negedge clk_50m) begin din8 = d; wr_en8 = 1'b1; end
    @(negedge clk_50m) wr_en8 = 1'b0;
  endtask

  task automatic push5(input logic [4:0] d);
    @(negedge clk_50m) begin din5 = d; wr_en5 = 1'b1; end
    @(negedge clk_50m) wr_en5 = 1'b0;
  endtask

  task automatic pulse_ovf_clr();
    @(negedge clk_50m) ovf_clr = 1'b1;
    @(negedge clk_50m) ovf_clr = 1'b0;
  endtask

  // Tick n times and compare each launched bit against the queue head.
  task automatic drain(input bit use5, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      logic       obs;
      logic [0:0] exp;
      tick();
      obs = use5 ? tx5 : tx8;
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL %s bit %0d: tx=%b but no bit expected", tag, i, obs);
      end else begin
        exp = exp_q.pop_front();
        if (obs !== exp[0]) begin
          fails++;
          $display("FAIL %s bit %0d: tx=%b expected %b", tag, i, obs, exp[0]);
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk_50m);
    rst_n = 1'b1;
    @(negedge clk_50m);
    checks++;
    if (tx8 !== 1'b1) begin fails++; $display("FAIL reset_tx: tx=%b expected 1", tx8); end
    checks++;
    if (busy8 !== 1'b0) begin fails++; $display("FAIL reset_busy: tx_busy=%b expected 0", busy8); end
    checks++;
    if (empty8 !== 1'b1 || full8 !== 1'b0) begin
      fails++; $display("FAIL reset_flags: empty=%b full=%b expected 1 0", empty8, full8);
    end
    checks++;
    if (level8 !== 3'd0) begin fails++; $display("FAIL reset_level: level=%0d expected 0", level8); end
    checks++;
    if (ovf8 !== 1'b0) begin fails++; $display("FAIL reset_ovf: overflow=%b expected 0", ovf8); end
    checks++;
    if (state8 !== ST_IDLE) begin fails++; $display("FAIL reset_state: state=%0d expected IDLE", state8); end
    checks++;
    if (tx5 !== 1'b1 || busy5 !== 1'b0) begin
      fails++; $display("FAIL reset_w5: tx=%b busy=%b expected 1 0", tx5, busy5);
    end
  endtask

  task automatic test_basic();
    parity_mode = PAR_NONE; stop2 = 1'b0;
    push8(8'hA5);
    model_frame({1'b0, 8'hA5}, 8, PAR_NONE, 1'b0);
    checks++;
    if (level8 !== 3'd1) begin fails++; $display("FAIL a5_level: level=%0d expected 1", level8); end
    drain(0, 1, "a5_start");
    checks++;
    if (busy8 !== 1'b1) begin fails++; $display("FAIL a5_busy_on: tx_busy=%b expected 1", busy8); end
    drain(0, 9, "a5_frame");
    checks++;
    if (busy8 !== 1'b0) begin fails++; $display("FAIL a5_busy_off: tx_busy=%b expected 0", busy8); end
  endtask

  task automatic test_parity();
    parity_mode = PAR_EVEN; stop2 = 1'b0;
    push8(8'h07);
    model_frame({1'b0, 8'h07}, 8, PAR_EVEN, 1'b0);
    drain(0, 11, "even_07");
    parity_mode = PAR_ODD; stop2 = 1'b1;
    push8(8'h07);
    push8(8'h07);
    model_frame({1'b0, 8'h07}, 8, PAR_ODD, 1'b1);
    model_frame({1'b0, 8'h07}, 8, PAR_ODD, 1'b1);
    drain(0, 24, "odd_07_stop2");
  endtask

  task automatic test_latch();
    parity_mode = PAR_EVEN; stop2 = 1'b0;
    push8(8'h03);
    model_frame({1'b0, 8'h03}, 8, PAR_EVEN, 1'b0);
    drain(0, 3, "latch_head");
    parity_mode = PAR_NONE; stop2 = 1'b1;
    drain(0, 8, "latch_tail");
    checks++;
    if (busy8 !== 1'b0) begin fails++; $display("FAIL latch_busy: tx_busy=%b expected 0", busy8); end
    parity_mode = PAR_NONE; stop2 = 1'b0;
  endtask

  task automatic test_overflow();
    logic [0:0] exp;
    parity_mode = PAR_NONE; stop2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push8(8'h40 + 8'(i));
      model_frame({1'b0, 8'h40 + 8'(i)}, 8, PAR_NONE, 1'b0);
    end
    checks++;
    if (full8 !== 1'b1 || level8 !== 3'd4 || ovf8 !== 1'b0) begin
      fails++; $display("FAIL fill4: full=%b level=%0d ovf=%b expected 1 4 0", full8, level8, ovf8);
    end
    checks++;
    if (tx8 !== 1'b1 || busy8 !== 1'b0) begin
      fails++; $display("FAIL hold_no_clken: tx=%b busy=%b expected 1 0", tx8, busy8);
    end
    push8(8'h55);
    checks++;
    if (ovf8 !== 1'b1 || level8 !== 3'd4) begin
      fails++; $display("FAIL ovf_set: ovf=%b level=%0d expected 1 4", ovf8, level8);
    end
    pulse_ovf_clr();
    checks++;
    if (ovf8 !== 1'b0) begin fails++; $display("FAIL ovf_clr: overflow=%b expected 0", ovf8); end
    @(negedge clk_50m) begin din8 = 8'h77; wr_en8 = 1'b1; ovf_clr = 1'b1; end
    @(negedge clk_50m) begin wr_en8 = 1'b0; ovf_clr = 1'b0; end
    checks++;
    if (ovf8 !== 1'b1) begin fails++; $display("FAIL ovf_priority: overflow=%b expected 1", ovf8); end
    pulse_ovf_clr();
    // Write while full coinciding with a pop is still dropped.
    @(negedge clk_50m) begin din8 = 8'h66; wr_en8 = 1'b1; clken = 1'b1; end
    @(negedge clk_50m) begin wr_en8 = 1'b0; clken = 1'b0; end
    checks++;
    if (ovf8 !== 1'b1 || level8 !== 3'd3) begin
      fails++; $display("FAIL ovf_with_pop: ovf=%b level=%0d expected 1 3", ovf8, level8);
    end
    exp = exp_q.pop_front();
    checks++;
    if (tx8 !== exp[0]) begin fails++; $display("FAIL ovf_pop_start: tx=%b expected %b", tx8, exp[0]); end
    drain(0, 39, "ovf_drain");
    checks++;
    if (empty8 !== 1'b1) begin fails++; $display("FAIL ovf_empty: empty=%b expected 1", empty8); end
    pulse_ovf_clr();
  endtask

  task automatic test_back_to_back();
    parity_mode = PAR_NONE; stop2 = 1'b0;
    push8(8'h11); push8(8'h22); push8(8'h33);
    model_frame({1'b0, 8'h11}, 8, PAR_NONE, 1'b0);
    model_frame({1'b0, 8'h22}, 8, PAR_NONE, 1'b0);
    model_frame({1'b0, 8'h33}, 8, PAR_NONE, 1'b0);
    drain(0, 11, "b2b_first");
    checks++;
    if (level8 !== 3'd1 || empty8 !== 1'b0) begin
      fails++; $display("FAIL b2b_level: level=%0d empty=%b expected 1 0", level8, empty8);
    end
    drain(0, 10, "b2b_second");
    checks++;
    if (empty8 !== 1'b1) begin fails++; $display("FAIL b2b_empty: empty=%b expected 1", empty8); end
    drain(0, 9, "b2b_third");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      logic [1:0] m;
      logic       s2;
      int         n;
      int         bits;
      m  = 2'($urandom_range(0, 3));
      s2 = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 3);
      parity_mode = m; stop2 = s2;
      bits = 0;
      for (int k = 0; k < n; k++) begin
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        push8(d);
        model_frame({1'b0, d}, 8, m, s2);
        bits += 10 + ((m == 2'b01 || m == 2'b10) ? 1 : 0) + (s2 ? 1 : 0);
      end
      drain(0, bits, "random");
    end
    parity_mode = PAR_NONE; stop2 = 1'b0;
  endtask

  task automatic test_reset_mid();
    parity_mode = PAR_NONE; stop2 = 1'b0;
    push8(8'h00); push8(8'hFF); push8(8'hFF);
    repeat (5) tick();
    checks++;
    if (tx8 !== 1'b0 || busy8 !== 1'b1) begin
      fails++; $display("FAIL mid_bit3: tx=%b busy=%b expected 0 1", tx8, busy8);
    end
    #5 rst_n = 1'b0;
    #1;
    checks++;
    if (tx8 !== 1'b1 || busy8 !== 1'b0 || level8 !== 3'd0 || empty8 !== 1'b1) begin
      fails++; $display("FAIL mid_reset: tx=%b busy=%b level=%0d empty=%b expected 1 0 0 1",
                        tx8, busy8, level8, empty8);
    end
    @(negedge clk_50m) rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if (tx8 !== 1'b1 || busy8 !== 1'b0) begin
        fails++; $display("FAIL post_reset tick %0d: tx=%b busy=%b expected 1 0", i, tx8, busy8);
      end
    end
  endtask

  task automatic test_w5();
    parity_mode = PAR_ODD; stop2 = 1'b0;
    push5(5'h1F);
    model_frame(9'h01F, 5, PAR_ODD, 1'b0);
    drain(1, 8, "w5_odd_1f");
    checks++;
    if (busy5 !== 1'b0 || empty5 !== 1'b1) begin
      fails++; $display("FAIL w5_done: busy=%b empty=%b expected 0 1", busy5, empty5);
    end
    parity_mode = PAR_NONE;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_latch();
    test_overflow();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_w5();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
